// File: rtl/net_delay_and_pkg.sv
// Shared constants and helpers for the net_delay_and gate-plus-delay model.
// MODE selects inertial (glitch-swallowing) or transport (pure shift) delay.
package net_delay_and_pkg;

    localparam int MODE_INERTIAL  = 0;
    localparam int MODE_TRANSPORT = 1;

    // Bits needed to hold values 0 .. value-1.
    function automatic int clog2(input int value);
        int result;
        int rest;
        result = 0;
        rest   = value - 1;
        while (rest > 0) begin
            result = result + 1;
            rest   = rest >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/net_delay_chan.sv
// One channel: AND of WIDTH inputs followed by a DELAY-cycle inertial or
// transport delay, with glitch-reject and change-in-flight flags.
module net_delay_chan
    import net_delay_and_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DELAY = 10,
    parameter int MODE  = MODE_INERTIAL
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    output logic             out,
    output logic             reject,
    output logic             pending
);

    logic a;

    always_comb begin
        a = &in;
    end

    generate
        if (MODE == MODE_TRANSPORT) begin : g_transport
            logic [DELAY-1:0] stages;

            always_ff @(posedge clock) begin
                if (!reset) begin
                    stages <= '0;
                end else begin
                    stages[0] <= a;
                    for (int unsigned i = 1; i < DELAY; i++) begin
                        stages[i] <= stages[i-1];
                    end
                end
            end

            always_comb begin
                out     = stages[DELAY-1];
                pending = |(stages ^ {DELAY{stages[DELAY-1]}});
                reject  = 1'b0;
            end
        end else begin : g_inertial
            localparam int CNT_W = clog2(DELAY + 1);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY - 1);

            logic [CNT_W-1:0] cnt;
            logic             out_q;
            logic             reject_q;

            // cnt tracks how long a has disagreed with out; a return to
            // agreement before it reaches DELAY-1 is the swallowed glitch.
            always_ff @(posedge clock) begin
                if (!reset) begin
                    out_q    <= 1'b0;
                    cnt      <= '0;
                    reject_q <= 1'b0;
                end else if (a != out_q) begin
                    reject_q <= 1'b0;
                    if (cnt == CNT_LAST) begin
                        out_q <= a;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end else begin
                    reject_q <= (cnt != '0);
                    cnt      <= '0;
                end
            end

            always_comb begin
                out     = out_q;
                reject  = reject_q;
                pending = (cnt != '0);
            end
        end
    endgenerate

endmodule

// File: rtl/net_delay_and.sv
// CHANNELS independent AND gates, each driving its output through a
// cycle-accurate net delay; channels never interact.
module net_delay_and
    import net_delay_and_pkg::*;
#(
    parameter int WIDTH    = 2,
    parameter int CHANNELS = 4,
    parameter int DELAY    = 10,
    parameter int MODE     = MODE_INERTIAL
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] in,
    output logic [CHANNELS-1:0]       out,
    output logic [CHANNELS-1:0]       reject,
    output logic [CHANNELS-1:0]       pending
);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        net_delay_chan #(
            .WIDTH(WIDTH),
            .DELAY(DELAY),
            .MODE (MODE)
        ) u_chan (
            .clock  (clock),
            .reset  (reset),
            .in     (in[c*WIDTH +: WIDTH]),
            .out    (out[c]),
            .reject (reject[c]),
            .pending(pending[c])
        );
    end

endmodule

// File: tb/tb_net_delay_and.sv
// Bench for net_delay_and: inertial DELAY=10, transport DELAY=10 and
// inertial DELAY=1 builds share one stimulus and a history-based model.
module tb_net_delay_and;

    localparam int W    = 2;
    localparam int CH   = 4;
    localparam int D    = 10;
    localparam int MAXT = 4096;

    logic          clock;
    logic          reset;
    logic [CH*W-1:0] in_v;

    logic [CH-1:0] out_i, rej_i, pend_i;
    logic [CH-1:0] out_t, rej_t, pend_t;
    logic [CH-1:0] out_d, rej_d, pend_d;

    int checks = 0;
    int errors = 0;

    net_delay_and #(.WIDTH(W), .CHANNELS(CH), .DELAY(D), .MODE(0)) u_inert (
        .clock(clock), .reset(reset), .in(in_v),
        .out(out_i), .reject(rej_i), .pending(pend_i));

    net_delay_and #(.WIDTH(W), .CHANNELS(CH), .DELAY(D), .MODE(1)) u_trans (
        .clock(clock), .reset(reset), .in(in_v),
        .out(out_t), .reject(rej_t), .pending(pend_t));

    net_delay_and #(.WIDTH(W), .CHANNELS(CH), .DELAY(1), .MODE(0)) u_d1 (
        .clock(clock), .reset(reset), .in(in_v),
        .out(out_d), .reject(rej_d), .pending(pend_d));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: per-channel history of AND samples ----------
    bit            hist [CH][MAXT];
    int            n = 0;
    logic [CH-1:0] m_out_i, m_rej_i, m_pend_i;
    logic [CH-1:0] m_out_t, m_pend_t;
    logic [CH-1:0] m_out_d;

    // Sample k since reset (0-based); before reset counts as 0.
    function automatic bit h(input int c, input int k);
        if (k < 0) return 1'b0;
        return hist[c][k];
    endfunction

    always @(posedge clock) begin
        if (!reset) begin
            n        = 0;
            m_out_i  = '0;
            m_rej_i  = '0;
            m_pend_i = '0;
            m_out_t  = '0;
            m_pend_t = '0;
            m_out_d  = '0;
        end else begin
            for (int c = 0; c < CH; c++) hist[c][n] = &in_v[c*W +: W];
            if (n < MAXT - 1) n = n + 1;
            for (int c = 0; c < CH; c++) begin
                bit o_old;
                bit all_diff;
                bit any_diff;
                // Inertial: change only after D consecutive opposite samples.
                o_old    = m_out_i[c];
                all_diff = 1'b1;
                for (int j = 0; j < D; j++)
                    if (h(c, n-1-j) == o_old) all_diff = 1'b0;
                m_rej_i[c] = (h(c, n-1) == o_old) && (h(c, n-2) != o_old);
                if (all_diff) m_out_i[c] = ~o_old;
                m_pend_i[c] = (h(c, n-1) != m_out_i[c]);
                // Transport: out is the sample taken D edges ago.
                m_out_t[c] = h(c, n-D);
                any_diff   = 1'b0;
                for (int j = 0; j < D; j++)
                    if (h(c, n-1-j) != m_out_t[c]) any_diff = 1'b1;
                m_pend_t[c] = any_diff;
                m_out_d[c]  = h(c, n-1);
            end
        end
        #1;
        chk("model_inert_out", 32'(out_i), 32'(m_out_i));
        chk("model_inert_reject", 32'(rej_i), 32'(m_rej_i));
        chk("model_inert_pending", 32'(pend_i), 32'(m_pend_i));
        chk("model_trans_out", 32'(out_t), 32'(m_out_t));
        chk("model_trans_reject", 32'(rej_t), 32'(0));
        chk("model_trans_pending", 32'(pend_t), 32'(m_pend_t));
        chk("model_d1_out", 32'(out_d), 32'(m_out_d));
        chk("model_d1_flags", 32'({rej_d, pend_d}), 32'(0));
    end

    // ---------------- directed stimulus with literal expectations --------
    logic [7:0] tbl_val  [8] = '{8'hFF, 8'h00, 8'h55, 8'hFF, 8'hF3, 8'hFF, 8'h0C, 8'hFF};
    int         tbl_hold [8] = '{3, 12, 4, 11, 1, 15, 10, 12};

    initial begin
        int rej_cnt, rej_edge, low_i, low_t, low_d, first_t, first_i, viol;
        reset = 1'b0;
        in_v  = '1;

        // Reset held with all inputs high.
        repeat (3) begin
            @(negedge clock);
            chk("reset_out", 32'({out_i, out_t, out_d}), 32'(0));
            chk("reset_flags", 32'({rej_i, pend_i, pend_t}), 32'(0));
        end

        // Release: output rises on the 10th edge, pending for 9 cycles before.
        reset = 1'b1;
        for (int k = 1; k <= D; k++) begin
            @(negedge clock);
            if (k == 1) chk("d1_latency", 32'(out_d), 32'hF);
            if (k < D) begin
                chk("rise_wait_out", 32'({out_i, out_t}), 32'(0));
                chk("rise_wait_pending", 32'({pend_i, pend_t}), 32'hFF);
            end else begin
                chk("rise_out", 32'({out_i, out_t}), 32'hFF);
                chk("rise_pending", 32'({pend_i, pend_t}), 32'(0));
            end
        end
        repeat (2) @(negedge clock);

        // 5-cycle low pulse on channel 0.
        in_v[0] = 1'b0;
        rej_cnt = 0; rej_edge = 0; low_i = 0; low_t = 0; low_d = 0; first_t = 0;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clock);
            if (rej_i[0]) begin rej_cnt++; rej_edge = k; end
            if (!out_i[0]) low_i++;
            if (!out_t[0]) begin low_t++; if (first_t == 0) first_t = k; end
            if (!out_d[0]) low_d++;
            if (k == 5) in_v[0] = 1'b1;
        end
        chk("p5_inert_reject_count", 32'(rej_cnt), 32'(1));
        chk("p5_inert_reject_edge", 32'(rej_edge), 32'(6));
        chk("p5_inert_out_stays", 32'(low_i), 32'(0));
        chk("p5_trans_low_len", 32'(low_t), 32'(5));
        chk("p5_trans_low_start", 32'(first_t), 32'(10));
        chk("p5_d1_low_len", 32'(low_d), 32'(5));

        // Exactly DELAY samples low: output follows on the 10th edge.
        in_v[0] = 1'b0;
        rej_cnt = 0; low_i = 0; first_i = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clock);
            if (rej_i[0]) rej_cnt++;
            if (!out_i[0]) begin low_i++; if (first_i == 0) first_i = k; end
            if (k == 10) in_v[0] = 1'b1;
        end
        chk("p10_fall_edge", 32'(first_i), 32'(10));
        chk("p10_low_len", 32'(low_i), 32'(10));
        chk("p10_no_reject", 32'(rej_cnt), 32'(0));

        // DELAY-1 samples low: swallowed, rejected on the 10th edge.
        in_v[0] = 1'b0;
        rej_cnt = 0; rej_edge = 0; low_i = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            if (rej_i[0]) begin rej_cnt++; rej_edge = k; end
            if (!out_i[0]) low_i++;
            if (k == 9) in_v[0] = 1'b1;
        end
        chk("p9_out_stays", 32'(low_i), 32'(0));
        chk("p9_reject_count", 32'(rej_cnt), 32'(1));
        chk("p9_reject_edge", 32'(rej_edge), 32'(10));

        // Only channel 2 toggles; other channels must stay static.
        in_v[4] = 1'b0;
        viol = 0; first_i = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clock);
            if ((out_i & 4'b1011) != 4'b1011) viol++;
            if ((out_t & 4'b1011) != 4'b1011) viol++;
            if (((rej_i | pend_i | pend_t) & 4'b1011) != 4'b0000) viol++;
            if (!out_i[2] && first_i == 0) first_i = k;
            if (k == 12) in_v[4] = 1'b1;
        end
        chk("ch2_isolation", 32'(viol), 32'(0));
        chk("ch2_fall_edge", 32'(first_i), 32'(10));

        // Reset in the middle of a change (cnt reaches 6).
        in_v[0] = 1'b0;
        repeat (6) @(negedge clock);
        chk("mid_pending_before", 32'(pend_i[0]), 32'(1));
        reset = 1'b0;
        @(negedge clock);
        chk("mid_reset_out", 32'({out_i, out_t, out_d}), 32'(0));
        chk("mid_reset_flags", 32'({rej_i, pend_i, pend_t}), 32'(0));
        reset = 1'b1;
        in_v  = '1;

        // Mixed patterns across all channels; checked by the model.
        for (int e = 0; e < 8; e++) begin
            in_v = tbl_val[e];
            repeat (tbl_hold[e]) @(negedge clock);
        end
        repeat (12) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
